alu_arbiter: RTL

//  Shares the single combinational 64-bit ALU between NREQ requesters (EX stage, branch/address unit).

---
 rtl/alu_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/alu_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ALU opcode encodings and legality check shared by the ALU arbiter slice.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_NOR = 4'b1100
   } alu_op_t;

   function automatic logic alu_op_legal(input logic [3:0] op);
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at/after the pointer.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [NREQ-1:0]                         i_req,
   input  logic                                    i_adv,
   output logic [NREQ-1:0]                         o_grant,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] o_idx
);

   localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned NR = NREQ;

   logic [PW-1:0]   r_ptr;
   logic [NREQ-1:0] w_grant;
   logic [PW-1:0]   w_idx;
   logic            w_found;

   // Scan from the pointer with wrap-around; the first hit wins.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int unsigned k = 0; k < NR; k++) begin
         if (!w_found && i_req[(32'(r_ptr) + k) % NR]) begin
            w_found = 1'b1;
            w_idx   = PW'((32'(r_ptr) + k) % NR);
            w_grant[(32'(r_ptr) + k) % NR] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_adv) begin
         r_ptr <= (32'(w_idx) == NR - 1) ? '0 : w_idx + 1'b1;
      end
   end

   assign o_grant = w_grant;
   assign o_idx   = w_idx;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NREQ requesters: round-robin accept,
// registered issue to the ALU, registered capture of the result.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*4-1:0]     req_op,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_result,
   output logic                  rsp_zero,
   output logic                  rsp_err,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [3:0]            alu_op,
   input  logic [WIDTH-1:0]      alu_result,
   input  logic                  alu_zero,
   output logic                  busy
);

   localparam int          PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned NR = NREQ;
   localparam int unsigned WU = WIDTH;

   logic [NREQ-1:0]  w_grant;
   logic [PW-1:0]    w_gnt_idx;
   logic             w_accept;
   logic [WIDTH-1:0] w_sel_a;
   logic [WIDTH-1:0] w_sel_b;
   logic [3:0]       w_sel_op;
   logic             w_sel_legal;
   logic [WIDTH-1:0] w_cap_val;
   logic             w_unused_zero;

   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [3:0]       r_alu_op;
   logic [PW-1:0]    r_iss_id;
   logic             r_iss_legal;
   logic             r_busy;
   logic [NREQ-1:0]  r_rsp_valid;
   logic [WIDTH-1:0] r_rsp_result;
   logic             r_rsp_zero;
   logic             r_rsp_err;

   // The ALU's own zero flag is not trusted; zero is recomputed on the captured value.
   assign w_unused_zero = alu_zero;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (req_valid),
      .i_adv   (w_accept),
      .o_grant (w_grant),
      .o_idx   (w_gnt_idx)
   );

   assign req_ready = w_grant & {NREQ{~flush & rst_n}};
   assign w_accept  = |req_ready;

   always_comb begin
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_sel_op = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (w_grant[i]) begin
            w_sel_a  = req_a[i*WU +: WIDTH];
            w_sel_b  = req_b[i*WU +: WIDTH];
            w_sel_op = req_op[i*4 +: 4];
         end
      end
      w_sel_legal = alu_op_legal(w_sel_op);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_op    <= ALU_ADD;
         r_iss_id    <= '0;
         r_iss_legal <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_busy <= w_accept;
         if (w_accept) begin
            r_alu_a     <= w_sel_legal ? w_sel_a : '0;
            r_alu_b     <= w_sel_legal ? w_sel_b : '0;
            r_alu_op    <= w_sel_legal ? w_sel_op : ALU_ADD;
            r_iss_id    <= w_gnt_idx;
            r_iss_legal <= w_sel_legal;
         end
      end
   end

   assign w_cap_val = r_iss_legal ? alu_result : '0;

   // A flush at the capture edge kills the issue-stage op; result flags hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid  <= '0;
         r_rsp_result <= '0;
         r_rsp_zero   <= 1'b0;
         r_rsp_err    <= 1'b0;
      end else begin
         r_rsp_valid <= '0;
         if (r_busy && !flush) begin
            r_rsp_valid  <= {{(NREQ-1){1'b0}}, 1'b1} << r_iss_id;
            r_rsp_result <= w_cap_val;
            r_rsp_zero   <= (w_cap_val == '0);
            r_rsp_err    <= ~r_iss_legal;
         end
      end
   end

   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_op     = r_alu_op;
   assign busy       = r_busy;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign rsp_zero   = r_rsp_zero;
   assign rsp_err    = r_rsp_err;

endmodule
